// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
//
// Purpose: FSM state encoding, master IDs, load/store control codes and the
// store-detect helper used by mem_arbiter and mem_arb_pick.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef logic mst_t;
  localparam mst_t MST_IF = 1'b0;
  localparam mst_t MST_LS = 1'b1;

  // Load/store control codes; bit 3 marks a store.
  localparam logic [3:0] Load_8Bytes   = 4'b0000;
  localparam logic [3:0] Load_4Bytes   = 4'b0001;
  localparam logic [3:0] Load_2Bytes   = 4'b0010;
  localparam logic [3:0] Load_1Byte    = 4'b0011;
  localparam logic [3:0] Load_4BytesU  = 4'b0100;
  localparam logic [3:0] Load_2BytesU  = 4'b0101;
  localparam logic [3:0] Load_1ByteU   = 4'b0110;
  localparam logic [3:0] Store_8Bytes  = 4'b1000;
  localparam logic [3:0] Store_4Bytes  = 4'b1001;
  localparam logic [3:0] Store_2Bytes  = 4'b1010;
  localparam logic [3:0] Store_1Byte   = 4'b1011;

  function automatic logic is_store(input logic [3:0] ctrl);
    return ctrl[3];
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational two-master grant
//
// Purpose: picks the winner between the IFU and LSU requests.
//   Default build: LSU has fixed priority over IFU.
//   With MEM_ARB_RR_EN defined: when both request, the master that was not
//   the last owner wins; a single requester always wins.
// Ports:
//   if_req, ls_req        request present from IFU / LSU
//   last_owner            previous owner (MEM_ARB_RR_EN builds only)
//   grant_if, grant_ls    one-hot (or zero) grant
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
`ifdef MEM_ARB_RR_EN
  input  mst_t last_owner,
`endif
  output logic grant_if,
  output logic grant_ls
);

`ifdef MEM_ARB_RR_EN
  assign grant_ls = ls_req && (!if_req || (last_owner == MST_IF));
  assign grant_if = if_req && (!ls_req || (last_owner == MST_LS));
`else
  assign grant_ls = ls_req;
  assign grant_if = if_req && !ls_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU arbiter in front of the data-memory port
//
// Purpose: shares one memory port between instruction fetch (master 0) and
// load/store (master 1). One transaction outstanding at a time:
// IDLE (arbitrate) -> REQ (drive request) -> WAIT (await response, watchdog)
// -> RESP (return to owner). Optional macro MEM_ARB_RR_EN selects
// round-robin arbitration instead of fixed LSU priority.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   if_req_valid/ready, if_addr           IFU request
//   if_resp_valid/ready, if_rdata, if_resp_err   IFU response
//   ls_req_valid/ready, ls_addr, ls_wdata, ls_ctrl  LSU request
//   ls_resp_valid/ready, ls_rdata, ls_resp_err      LSU response
//   mem_req_valid/ready, mem_addr, mem_wdata, mem_ctrl  downstream request
//   mem_resp_valid, mem_rdata             downstream one-cycle response
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_resp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [CTRL_W-1:0] ls_ctrl,
  output logic              ls_resp_valid,
  input  logic              ls_resp_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [CTRL_W-1:0] mem_ctrl,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The timeout fires in the WAIT cycle whose increment would reach TIMEOUT,
  // so exactly TIMEOUT cycles are spent in WAIT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  mst_t              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic              if_err_q, ls_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant_if, grant_ls;
  logic              timed_out;
  logic [DATA_W-1:0] cap_data;

  mem_arb_pick u_pick (
    .if_req     (if_req_valid),
    .ls_req     (ls_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_owner (owner_q),
`endif
    .grant_if   (grant_if),
    .grant_ls   (grant_ls)
  );

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_ctrl    = ctrl_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign if_resp_err = if_err_q;
  assign ls_resp_err = ls_err_q;

  // A simultaneous response beats the timeout.
  assign timed_out = !mem_resp_valid && (cnt_q == CNT_LAST);
  assign cap_data  = is_store(ctrl_q[3:0]) ? '0 : mem_rdata;

  always_comb begin
    state_d       = state_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Held off during reset so no handshake is reported that reset discards.
        if (!rst) begin
          if_req_ready = grant_if;
          ls_req_ready = grant_ls;
          if (grant_if || grant_ls) state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem_resp_valid || timed_out) state_d = RESP;
      end
      RESP: begin
        if (owner_q == MST_IF) begin
          if_resp_valid = 1'b1;
          if (if_resp_ready) state_d = IDLE;
        end else begin
          ls_resp_valid = 1'b1;
          if (ls_resp_ready) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= MST_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      if_err_q   <= 1'b0;
      ls_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_ls) begin
            owner_q <= MST_LS;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            ctrl_q  <= ls_ctrl;
          end else if (grant_if) begin
            owner_q <= MST_IF;
            addr_q  <= if_addr;
            wdata_q <= '0;
            ctrl_q  <= CTRL_W'(Load_8Bytes);
          end
        end
        REQ: begin
          if (mem_req_ready) cnt_q <= '0;
        end
        WAIT: begin
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if (mem_resp_valid) begin
            if (owner_q == MST_IF) begin
              if_rdata_q <= cap_data;
              if_err_q   <= 1'b0;
            end else begin
              ls_rdata_q <= cap_data;
              ls_err_q   <= 1'b0;
            end
          end else if (timed_out) begin
            if (owner_q == MST_IF) begin
              if_rdata_q <= '0;
              if_err_q   <= 1'b1;
            end else begin
              ls_rdata_q <= '0;
              ls_err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_resp_valid, ls_resp_ready, ls_resp_err;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_ctrl;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_ctrl;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .CTRL_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
    .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ctrl(ls_ctrl),
    .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
    .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: pending requests per master (0=IFU, 1=LSU), the
  // response each master should currently see, and the last owner.
  bit          pend[2];
  logic [63:0] p_addr[2];
  logic [63:0] p_wdata;
  logic [3:0]  p_ctrl;
  logic [63:0] exp_rdata[2];
  bit          exp_err[2];
  int          last_owner = 0;
  int          raise_mode = 0;  // 0 random, 1 never, 2 always

  task automatic new_req(input int m);
    pend[m]   = 1'b1;
    p_addr[m] = {$urandom, $urandom};
    if (m == 1) begin
      p_wdata = {$urandom, $urandom};
      p_ctrl  = ($urandom_range(0, 1) == 1) ? 4'(8 + $urandom_range(0, 3))
                                            : 4'($urandom_range(0, 6));
    end
  endtask

  task automatic maybe_raise(input int m);
    if (!pend[m] && (raise_mode == 2 || (raise_mode == 0 && $urandom_range(0, 3) == 0)))
      new_req(m);
  endtask

  task automatic drive_reqs();
    if_req_valid = pend[0];
    if_addr      = p_addr[0];
    ls_req_valid = pend[1];
    ls_addr      = p_addr[1];
    ls_wdata     = p_wdata;
    ls_ctrl      = p_ctrl;
  endtask

  task automatic noise();
    mem_req_ready  = 1'($urandom_range(0, 1));
    mem_resp_valid = ($urandom_range(0, 3) == 0);
    mem_rdata      = {$urandom, $urandom};
    if_resp_ready  = 1'($urandom_range(0, 1));
    ls_resp_ready  = 1'($urandom_range(0, 1));
  endtask

  task automatic check_outs(input string ph, input bit e_ifr, input bit e_lsr,
                            input bit e_mrv, input bit e_ifv, input bit e_lsv);
    check({ph, ".if_req_ready"},  if_req_ready,  e_ifr);
    check({ph, ".ls_req_ready"},  ls_req_ready,  e_lsr);
    check({ph, ".mem_req_valid"}, mem_req_valid, e_mrv);
    check({ph, ".if_resp_valid"}, if_resp_valid, e_ifv);
    check({ph, ".ls_resp_valid"}, ls_resp_valid, e_lsv);
    check({ph, ".if_rdata"},      if_rdata,      exp_rdata[0]);
    check({ph, ".ls_rdata"},      ls_rdata,      exp_rdata[1]);
    check({ph, ".if_resp_err"},   if_resp_err,   exp_err[0]);
    check({ph, ".ls_resp_err"},   ls_resp_err,   exp_err[1]);
  endtask

  task automatic check_mem(input string ph, input logic [63:0] a,
                           input logic [63:0] w, input logic [3:0] c);
    check({ph, ".mem_addr"},  mem_addr,  a);
    check({ph, ".mem_wdata"}, mem_wdata, w);
    check({ph, ".mem_ctrl"},  mem_ctrl,  c);
  endtask

  // One transaction starting in IDLE with at least one request pending.
  // rd: cycles mem_req_ready stays low; dd: WAIT-cycle index of the memory
  // response (>= TIMEOUT means it never comes in time); bp: cycles of
  // response backpressure.
  task automatic run_txn(input int rd, input int dd, input int bp, input logic [63:0] data);
    int win, lose, wend;
    logic [63:0] e_addr, e_wdata;
    logic [3:0]  e_ctrl;
    bit store;
    if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
      win = (last_owner == 0) ? 1 : 0;
`else
      win = 1;
`endif
    end else begin
      win = pend[1] ? 1 : 0;
    end
    lose    = 1 - win;
    e_addr  = p_addr[win];
    e_wdata = (win == 1) ? p_wdata : 64'd0;
    e_ctrl  = (win == 1) ? p_ctrl : 4'd0;
    store   = (win == 1) && (p_ctrl >= 4'd8);

    @(negedge clk);
    noise();
    drive_reqs();
    #1 check_outs("grant", win == 0, win == 1, 1'b0, 1'b0, 1'b0);
    pend[win]  = 1'b0;
    last_owner = win;

    for (int i = 0; i <= rd; i++) begin
      @(negedge clk);
      noise();
      maybe_raise(lose);
      drive_reqs();
      mem_req_ready = (i == rd);
      #1 check_outs("req", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_mem("req", e_addr, e_wdata, e_ctrl);
    end

    wend = (dd < TIMEOUT) ? dd : TIMEOUT - 1;
    for (int i = 0; i <= wend; i++) begin
      @(negedge clk);
      noise();
      maybe_raise(lose);
      drive_reqs();
      mem_resp_valid = (i == dd);
      if (i == dd) mem_rdata = data;
      #1 check_outs("wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_mem("wait", e_addr, e_wdata, e_ctrl);
    end

    if (dd < TIMEOUT) begin
      exp_rdata[win] = store ? 64'd0 : data;
      exp_err[win]   = 1'b0;
    end else begin
      exp_rdata[win] = 64'd0;
      exp_err[win]   = 1'b1;
    end

    for (int i = 0; i <= bp; i++) begin
      @(negedge clk);
      noise();
      maybe_raise(lose);
      drive_reqs();
      if (i == 0 && dd >= TIMEOUT) mem_resp_valid = 1'b1;  // late response
      if (win == 0) if_resp_ready = (i == bp);
      else          ls_resp_ready = (i == bp);
      #1 check_outs("resp", 1'b0, 1'b0, 1'b0, win == 0, win == 1);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    noise();
    drive_reqs();
    #1 check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_in_wait();
    pend[0] = 1'b1;
    pend[1] = 1'b0;
    p_addr[0] = {$urandom, $urandom};
    @(negedge clk);
    noise();
    drive_reqs();
    #1 check("rstw.grant", if_req_ready, 1'b1);
    pend[0] = 1'b0;
    @(negedge clk);
    noise();
    drive_reqs();
    mem_req_ready = 1'b1;
    @(negedge clk);
    noise();
    mem_resp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    noise();
    rst = 1'b0;
    mem_resp_valid = 1'b1;  // the outstanding response, now stray
    exp_rdata[0] = 64'd0;
    exp_rdata[1] = 64'd0;
    exp_err[0]   = 1'b0;
    exp_err[1]   = 1'b0;
    last_owner   = 0;
    #1 check_outs("rstw", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_mem("rstw", 64'd0, 64'd0, 4'd0);
    idle_cycle();
  endtask

  initial begin
    rst = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    p_addr[0] = 64'd0;
    p_addr[1] = 64'd0;
    p_wdata = 64'd0;
    p_ctrl = 4'd0;
    exp_rdata[0] = 64'd0;
    exp_rdata[1] = 64'd0;
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
    drive_reqs();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata = 64'd0;
    if_resp_ready = 1'b0;
    ls_resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_mem("reset", 64'd0, 64'd0, 4'd0);

    // Single IFU fetch, zero-wait memory.
    raise_mode = 1;
    pend[0] = 1'b1;
    p_addr[0] = 64'h0000_0000_8000_0000;
    run_txn(0, 0, 0, 64'h0000_0013_0000_0297);

    // LSU alone, then both at once.
    new_req(1);
    run_txn(0, 0, 0, {$urandom, $urandom});
    new_req(0);
    new_req(1);
    run_txn(0, 1, 0, {$urandom, $urandom});
    run_txn(0, 0, 0, {$urandom, $urandom});

    // Store held off by mem_req_ready for 5 cycles.
    pend[1] = 1'b1;
    p_addr[1] = 64'h0000_0000_8000_1000;
    p_wdata = 64'h0000_0000_DEAD_BEEF;
    p_ctrl = 4'b1001;
    run_txn(5, 1, 0, 64'h1234_5678_9ABC_DEF0);

    // Watchdog: no response, response on the last WAIT cycle, response one too late.
    new_req(1);
    p_ctrl = 4'b0000;
    run_txn(0, TIMEOUT + 5, 0, 64'h0);
    new_req(1);
    p_ctrl = 4'b0000;
    run_txn(0, TIMEOUT - 1, 0, 64'hA5A5_0000_5A5A_FFFF);
    new_req(0);
    run_txn(2, TIMEOUT, 1, 64'h0BAD_0BAD_0BAD_0BAD);

    // IFU response backpressure with an LSU request arriving meanwhile.
    new_req(0);
    raise_mode = 2;
    run_txn(0, 0, 4, {$urandom, $urandom});
    raise_mode = 1;
    run_txn(0, 0, 0, {$urandom, $urandom});

    reset_in_wait();
    pend[0] = 1'b1;
    p_addr[0] = {$urandom, $urandom};
    run_txn(0, 0, 0, {$urandom, $urandom});

    raise_mode = 0;
    for (int t = 0; t < 300; t++) begin
      if (!pend[0] && $urandom_range(0, 1) == 1) new_req(0);
      if (!pend[1] && $urandom_range(0, 1) == 1) new_req(1);
      if (pend[0] || pend[1]) begin
        run_txn(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 2))
                                            : int'($urandom_range(0, 2)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                {$urandom, $urandom});
      end else begin
        idle_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
